control_unit: RTL and testbench

Multicycle sequencer for the RV32I datapath. Streams a boot image into instruction memory over the flash port, then runs a fetch/decode/execute loop by driving the datapath's `ir_wren`, `pc_inc` and `regfile_wren` strobes from the decoded `opcode`. It also counts retired instructions and stops on `SYSTEM` or on an unsupported opcode.

---
 rtl/control_unit.sv | 97 +++++++++
 tb/tb_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I sequencer; flash boot loader enabled by CONTROL_UNIT_FLASH_BOOT_EN
module control_unit #(
  parameter int WIDTH = 32,
  parameter int BOOT_WORDS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             run,
  input  logic             boot_valid,
  input  logic [WIDTH-1:0] boot_data,
  input  logic             boot_last,
  output logic             boot_ready,
  output logic             flash_en,
  output logic [10:0]      flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             ir_wren,
  output logic             pc_inc,
  output logic             regfile_wren,
  output logic             halted,
  output logic             illegal,
  output logic [31:0]      instret
);
  localparam logic [2:0] BOOT       = 3'd0;
  localparam logic [2:0] BOOT_FLUSH = 3'd1;
  localparam logic [2:0] FETCH      = 3'd2;
  localparam logic [2:0] LOAD_IR    = 3'd3;
  localparam logic [2:0] DECODE     = 3'd4;
  localparam logic [2:0] EXEC       = 3'd5;
  localparam logic [2:0] HALT       = 3'd6;
  localparam logic [2:0] TRAP       = 3'd7;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  logic [2:0] state, next;
  logic boot_done;
`ifdef CONTROL_UNIT_FLASH_BOOT_EN
  localparam logic [2:0] RESET_STATE = BOOT;
  localparam logic [10:0] LAST = 11'(BOOT_WORDS - 1);
  logic [10:0] count;
  logic hs;
  assign hs = boot_valid && boot_ready;
  assign boot_done = hs && (boot_last || count == LAST);
  // boot_ready is registered so it is low on the first cycle after reset
  always_ff @(posedge clk)
    if (!rst) begin
      count <= '0;
      flash_en <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      boot_ready <= 1'b0;
    end else begin
      flash_en <= hs;
      boot_ready <= next == BOOT;
      if (hs) begin
        flash_addr <= count;
        flash_data <= boot_data;
        count <= count + 11'd1;
      end
    end
`else
  localparam logic [2:0] RESET_STATE = FETCH;
  localparam int unused_words = BOOT_WORDS;
  logic unused_boot;
  assign unused_boot = ^{boot_valid, boot_data, boot_last};
  assign boot_done = 1'b0;
  assign boot_ready = 1'b0;
  assign flash_en = 1'b0;
  assign flash_addr = '0;
  assign flash_data = '0;
`endif
  always_comb begin
    next = state;
    case (state)
      BOOT:       next = boot_done ? BOOT_FLUSH : BOOT;
      BOOT_FLUSH: next = FETCH;
      FETCH:      next = run ? LOAD_IR : FETCH;
      LOAD_IR:    next = DECODE;
      DECODE:     next = opcode == OPC_OP ? EXEC : opcode == OPC_SYSTEM ? HALT : TRAP;
      EXEC:       next = FETCH;
      default:    next = state;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RESET_STATE;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= next;
      illegal <= illegal | (next == TRAP);
      if (state == EXEC) instret <= instret + 32'd1;
    end
  assign ir_wren = state == LOAD_IR;
  assign pc_inc = state == EXEC;
  assign regfile_wren = state == EXEC;
  assign halted = state == HALT || state == TRAP;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against an instruction-level model
module tb_control_unit;
  localparam int BW = 4;
  localparam logic [6:0] OPC = 7'h33;
  localparam logic [6:0] SYS = 7'h73;
  logic clk = 0, rst = 0, run = 0, boot_valid = 0, boot_last = 0;
  logic [6:0] opcode = 0;
  logic [31:0] boot_data = 0;
  logic boot_ready, flash_en, ir_wren, pc_inc, regfile_wren, halted, illegal;
  logic [10:0] flash_addr;
  logic [31:0] flash_data, instret;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_instret = 0;
  bit m_halted = 0, m_illegal = 0;
  always #5 clk = ~clk;
  control_unit #(.WIDTH(32), .BOOT_WORDS(BW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .run(run),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .flash_en(flash_en), .flash_addr(flash_addr),
    .flash_data(flash_data), .ir_wren(ir_wren), .pc_inc(pc_inc),
    .regfile_wren(regfile_wren), .halted(halted), .illegal(illegal), .instret(instret)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_cycle(input bit ir, input bit ex, input bit fe, input bit br);
    chk("ir_wren", 32'(ir_wren), 32'(ir));
    chk("pc_inc", 32'(pc_inc), 32'(ex));
    chk("regfile_wren", 32'(regfile_wren), 32'(ex));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    chk("instret", instret, m_instret);
    chk("flash_en", 32'(flash_en), 32'(fe));
    chk("boot_ready", 32'(boot_ready), 32'(br));
  endtask
  task automatic do_reset();
    rst = 0;
    run = 0;
    boot_valid = 0;
    step();
    rst = 1;
    m_instret = 0;
    m_halted = 0;
    m_illegal = 0;
    @(negedge clk);
    chk_cycle(0, 0, 0, 0);
    chk("flash_addr_rst", 32'(flash_addr), 0);
    chk("flash_data_rst", flash_data, 0);
    step();
  endtask
`ifdef CONTROL_UNIT_FLASH_BOOT_EN
  task automatic boot_image(input int n, input bit use_last, input bit fixed);
    int cnt = 0, writes = 0;
    bit fe = 0, done = 0;
    logic [31:0] ea = 0, ed = 0;
    while (!done) begin
      boot_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
      boot_data = fixed ? 32'hAAAA0000 + 32'(cnt) : $urandom;
      boot_last = boot_valid ? (use_last && cnt == n - 1) : 1'($urandom);
      run = 1'($urandom);
      opcode = 7'($urandom);
      @(negedge clk);
      chk_cycle(0, 0, fe, 1);
      writes += int'(flash_en === 1'b1);
      if (fe) begin
        chk("flash_addr", 32'(flash_addr), ea);
        chk("flash_data", flash_data, ed);
      end
      fe = boot_valid;
      if (boot_valid) begin
        ea = 32'(cnt);
        ed = boot_data;
        done = boot_last || cnt == BW - 1;
        cnt++;
      end
      step();
    end
    boot_valid = 1;
    boot_data = $urandom;
    boot_last = 1'($urandom);
    @(negedge clk);
    chk_cycle(0, 0, 1, 0);
    writes += int'(flash_en === 1'b1);
    chk("flash_addr", 32'(flash_addr), ea);
    chk("flash_data", flash_data, ed);
    step();
    boot_valid = 0;
    boot_last = 0;
    run = 0;
    chk("boot_writes", 32'(writes), 32'(use_last ? n : BW));
  endtask
`endif
  task automatic boot_if();
`ifdef CONTROL_UNIT_FLASH_BOOT_EN
    boot_image($urandom_range(1, BW), 1, 0);
`endif
  endtask
  // Starts in a FETCH cycle; covers stall, one instruction, and the terminal hold
  task automatic do_instr(input logic [6:0] op, input int stall, input int hold, input bit abort);
    for (int i = 0; i < stall; i++) begin
      run = 0;
      opcode = 7'($urandom);
      @(negedge clk);
      chk_cycle(0, 0, 0, 0);
      step();
    end
    run = 1;
    opcode = op;
    @(negedge clk);
    chk_cycle(0, 0, 0, 0);
    step();
    run = 1'($urandom);
    @(negedge clk);
    chk_cycle(1, 0, 0, 0);
    step();
    run = 1'($urandom);
    @(negedge clk);
    chk_cycle(0, 0, 0, 0);
    if (abort) return;
    step();
    if (op == OPC) begin
      @(negedge clk);
      chk_cycle(0, 1, 0, 0);
      step();
      m_instret++;
    end else begin
      m_halted = 1;
      m_illegal = op != SYS;
      for (int i = 0; i < hold; i++) begin
        run = 1;
        opcode = 7'($urandom);
        @(negedge clk);
        chk_cycle(0, 0, 0, 0);
        step();
      end
    end
  endtask
  function automatic logic [6:0] pick_op();
    int r = $urandom_range(0, 9);
    logic [6:0] o = 7'($urandom);
    if (o == OPC || o == SYS) o = 7'h03;
    return r < 8 ? OPC : r == 8 ? SYS : o;
  endfunction
  initial begin
    do_reset();
`ifdef CONTROL_UNIT_FLASH_BOOT_EN
    boot_image(3, 1, 1);
`endif
    do_instr(OPC, 0, 0, 0);
    do_instr(OPC, 0, 0, 0);
    do_instr(OPC, 2, 0, 0);
    do_reset();
    boot_if();
    do_instr(OPC, 0, 0, 0);
    do_instr(SYS, 0, 20, 0);
    do_reset();
    boot_if();
    do_instr(7'h03, 0, 10, 0);
    do_reset();
    boot_if();
    do_instr(OPC, 0, 0, 0);
    do_instr(OPC, 5, 0, 1);
    do_reset();
    boot_if();
    do_instr(OPC, 0, 0, 0);
`ifdef CONTROL_UNIT_FLASH_BOOT_EN
    do_reset();
    boot_image(7, 0, 0);
    do_reset();
    boot_image(BW, 1, 0);
`else
    do_reset();
`endif
    for (int k = 0; k < 40; k++) begin
      do_instr(pick_op(), $urandom_range(0, 3), $urandom_range(1, 4), 0);
      if (m_halted) begin
        do_reset();
        boot_if();
      end
    end
    do_instr(SYS, 0, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
